// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a multiplexed 7-segment bus: recovers the BCD value on each digit,
// flags blank/illegal patterns and pulses once per completed scan frame.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SETTLE     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    err_pulse,
    output logic                    err_flag,
    output logic                    frame_done
);

    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CntMax = CW'(SETTLE);
    localparam logic [CW-1:0] CntCap = CW'(SETTLE - 1);
    localparam logic [NUM_DIGITS-1:0] SelOne = NUM_DIGITS'(1);
    localparam logic [4*NUM_DIGITS-1:0] BcdRst = {NUM_DIGITS{4'hA}};

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    state_e                  state_q, state_d;
    logic [6:0]              s_seg_q, s_seg_d;
    logic [NUM_DIGITS-1:0]   s_sel_q, s_sel_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    err_pulse_q, err_pulse_d;
    logic                    err_flag_q, err_flag_d;
    logic                    frame_q, frame_d;

    logic       changed, onehot_d, capture;
    logic       pat_legal, pat_blank;
    logic [3:0] pat_val;

    always_comb begin
        pat_legal = 1'b1;
        pat_blank = 1'b0;
        pat_val   = 4'hA;
        unique case (s_seg_q)
            7'b1111110: pat_val = 4'd0;
            7'b0110000: pat_val = 4'd1;
            7'b1101101: pat_val = 4'd2;
            7'b1111001: pat_val = 4'd3;
            7'b0110011: pat_val = 4'd4;
            7'b1011011: pat_val = 4'd5;
            7'b1011111: pat_val = 4'd6;
            7'b1110000: pat_val = 4'd7;
            7'b1111111: pat_val = 4'd8;
            7'b1111011: pat_val = 4'd9;
            7'b0000000: pat_blank = 1'b1;
            default:    pat_legal = 1'b0;
        endcase
    end

    always_comb begin
        s_seg_d     = seg;
        s_sel_d     = dig_sel;
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        bcd_d       = bcd_q;
        valid_d     = valid_q;
        blank_d     = blank_q;
        err_pulse_d = 1'b0;
        err_flag_d  = err_flag_q;
        frame_d     = 1'b0;
        capture     = 1'b0;

        changed  = {s_seg_d, s_sel_d} != {s_seg_q, s_sel_q};
        onehot_d = (s_sel_d != '0) && ((s_sel_d & (s_sel_d - SelOne)) == '0);

        unique case (state_q)
            StIdle: if (onehot_d) state_d = StSettle;
            StSettle: begin
                if (changed) begin
                    state_d = onehot_d ? StSettle : StIdle;
                end else if (cnt_q == CntCap) begin
                    capture = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: if (changed) state_d = onehot_d ? StSettle : StIdle;
            default: state_d = StIdle;
        endcase

        // Counter restarts on any input change and stays zero while idle.
        if (changed || state_q == StIdle || state_d == StIdle) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s_sel_q[i]) begin
                    if (pat_legal) begin
                        bcd_d[4*i +: 4] = pat_val;
                        valid_d[i]      = 1'b1;
                        blank_d[i]      = pat_blank;
                    end else begin
                        valid_d[i] = 1'b0;
                        blank_d[i] = 1'b0;
                    end
                end
            end
            if (!pat_legal) begin
                err_pulse_d = 1'b1;
                err_flag_d  = 1'b1;
            end
            if ((seen_q | s_sel_q) == '1) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d = seen_q | s_sel_q;
            end
        end

        // Clear beats a same-cycle capture; input registers keep sampling.
        if (clear) begin
            state_d     = StIdle;
            cnt_d       = '0;
            seen_d      = '0;
            bcd_d       = BcdRst;
            valid_d     = '0;
            blank_d     = '0;
            err_pulse_d = 1'b0;
            err_flag_d  = 1'b0;
            frame_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            s_seg_q     <= '0;
            s_sel_q     <= '0;
            cnt_q       <= '0;
            seen_q      <= '0;
            bcd_q       <= BcdRst;
            valid_q     <= '0;
            blank_q     <= '0;
            err_pulse_q <= 1'b0;
            err_flag_q  <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_seg_q     <= s_seg_d;
            s_sel_q     <= s_sel_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            blank_q     <= blank_d;
            err_pulse_q <= err_pulse_d;
            err_flag_q  <= err_flag_d;
            frame_q     <= frame_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_valid = valid_q;
    assign digit_blank = blank_q;
    assign err_pulse   = err_pulse_q;
    assign err_flag    = err_flag_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_seg7_scan_decoder;

    localparam int SETTLE = 4;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011;
    localparam logic [6:0] P7 = 7'b1110000, P8 = 7'b1111111, P9 = 7'b1111011;
    localparam logic [6:0] PBLK = 7'b0000000, PBAD = 7'b1000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = '0;
    logic [5:0]  dig_sel = '0;
    logic        clear = 1'b0;
    logic [23:0] bcd_out;
    logic [5:0]  digit_valid, digit_blank;
    logic        err_pulse, err_flag, frame_done;

    seg7_scan_decoder #(.NUM_DIGITS(6), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .clear       (clear),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .err_pulse   (err_pulse),
        .err_flag    (err_flag),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] bcd;
        logic [5:0]  v;
        logic [5:0]  b;
        logic        ep;
        logic        ef;
        logic        fd;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   total = 0;
    int   bad = 0;
    int   tag = 0;

    logic [23:0] m_bcd = 24'hAAAAAA;
    logic [5:0]  m_v = '0, m_b = '0;
    logic        m_ef = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= edge_n) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (e.cyc != edge_n) begin
                bad++;
                $display("FAIL stale tag=%0d: expectation for cycle %0d seen at cycle %0d",
                         e.tag, e.cyc, edge_n);
            end else if ({bcd_out, digit_valid, digit_blank, err_pulse, err_flag, frame_done}
                         !== {e.bcd, e.v, e.b, e.ep, e.ef, e.fd}) begin
                bad++;
                $display("FAIL outputs tag=%0d cyc=%0d: got bcd=%h v=%b b=%b ep=%b ef=%b fd=%b, want bcd=%h v=%b b=%b ep=%b ef=%b fd=%b",
                         e.tag, edge_n, bcd_out, digit_valid, digit_blank, err_pulse,
                         err_flag, frame_done, e.bcd, e.v, e.b, e.ep, e.ef, e.fd);
            end
        end
    end

    task automatic push(input int c, input logic ep, input logic fd);
        exp_t e;
        e.cyc = c; e.bcd = m_bcd; e.v = m_v; e.b = m_b;
        e.ep = ep; e.ef = m_ef; e.fd = fd; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_bcd = 24'hAAAAAA; m_v = '0; m_b = '0; m_ef = 1'b0;
    endtask

    // kind: 0 no capture, 1 legal digit, 2 blank, 3 illegal
    task automatic drive(input logic [6:0] s, input logic [5:0] d, input int n,
                         input int kind, input logic [3:0] nib, input logic fd);
        int e0;
        tag++;
        seg = s;
        dig_sel = d;
        e0 = edge_n + 1;
        for (int c = e0; c < e0 + n; c++) begin
            if (c == e0 + SETTLE && kind != 0) begin
                for (int i = 0; i < 6; i++) begin
                    if (d[i]) begin
                        case (kind)
                            1: begin m_bcd[4*i +: 4] = nib; m_v[i] = 1'b1; m_b[i] = 1'b0; end
                            2: begin m_bcd[4*i +: 4] = 4'hA; m_v[i] = 1'b1; m_b[i] = 1'b1; end
                            default: begin m_v[i] = 1'b0; m_b[i] = 1'b0; end
                        endcase
                    end
                end
                if (kind == 3) m_ef = 1'b1;
                push(c, kind == 3, fd);
            end else begin
                push(c, 1'b0, 1'b0);
            end
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        tag++;
        clear = 1'b1;
        seg = '0;
        dig_sel = '0;
        model_reset();
        push(edge_n + 1, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        // reset state
        push(1, 1'b0, 1'b0);
        push(2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // first capture latency
        drive(P4, 6'b000001, 6, 1, 4'd4, 1'b0);
        do_clear();

        // full scan, frame on sixth capture
        drive(P1, 6'b000001, 6, 1, 4'd1, 1'b0);
        drive(P2, 6'b000010, 6, 1, 4'd2, 1'b0);
        drive(P3, 6'b000100, 6, 1, 4'd3, 1'b0);
        drive(P4, 6'b001000, 6, 1, 4'd4, 1'b0);
        drive(P5, 6'b010000, 6, 1, 4'd5, 1'b0);
        drive(P9, 6'b100000, 6, 1, 4'd9, 1'b1);
        // seen mask must be empty again: no frame here
        drive(P1, 6'b000001, 6, 1, 4'd1, 1'b0);

        // blank then illegal on digit 2
        drive(PBLK, 6'b000100, 6, 2, 4'hA, 1'b0);
        drive(PBAD, 6'b000100, 6, 3, 4'h0, 1'b0);
        do_clear();

        // glitching shorter than the settle window, then one capture held long
        drive(P1, 6'b000001, 2, 0, 4'h0, 1'b0);
        drive(P2, 6'b000001, 2, 0, 4'h0, 1'b0);
        drive(P1, 6'b000001, 2, 0, 4'h0, 1'b0);
        drive(P2, 6'b000001, 2, 0, 4'h0, 1'b0);
        drive(PBAD, 6'b000001, 12, 3, 4'h0, 1'b0);
        do_clear();

        // multi-hot select is ignored
        drive(P1, 6'b000011, 10, 0, 4'h0, 1'b0);

        // clear on the capture edge
        drive(P1, 6'b000010, 6, 1, 4'd1, 1'b0);
        drive(PBAD, 6'b000010, 6, 3, 4'h0, 1'b0);
        drive(P0, 6'b000001, SETTLE, 0, 4'h0, 1'b0);
        do_clear();
        push(edge_n + 1, 1'b0, 1'b0);
        push(edge_n + 2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // async reset mid-settle, then a full window after release
        drive(P7, 6'b100000, 6, 1, 4'd7, 1'b0);
        drive(P8, 6'b001000, 2, 0, 4'h0, 1'b0);
        tag++;
        rst = 1'b1;
        model_reset();
        push(edge_n + 1, 1'b0, 1'b0);
        push(edge_n + 2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(P8, 6'b001000, 6, 1, 4'd8, 1'b0);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
